// File: rtl/c_mq_pkg.sv
// c_mq_pkg: shared definitions for the hybrid multi-queue tracker.
//
// Contents:
//   cnt_width(n)     bits needed to hold 0..n (never less than 1)
//   occ_width(p, c)  per-queue occupancy width, holds 0..p+c
//   pool_width(s)    shared pool counter width, holds 0..s
//   ERR_OVERFLOW / ERR_UNDERFLOW  bit offsets within each queue's 2-bit error field
package c_mq_pkg;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;

  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic int occ_width(input int p, input int c);
    return cnt_width(p + c);
  endfunction

  function automatic int pool_width(input int s);
    return cnt_width(s);
  endfunction

endpackage

// File: rtl/c_mq_queue_counter.sv
// c_mq_queue_counter: occupancy bookkeeping for one queue of the tracker.
//
// Optional feature macro: C_MQ_TRACKER_SHARED_EN (shared overflow pool).
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   push_acc/pop_acc  accepted push / pop this cycle (already qualified by
//                     active, full/empty and same-queue pairing in the top)
//   shared_avail      free slots in the shared pool       (shared build only)
//   shr_take          this queue claims a shared slot     (shared build only)
//   shr_release       this queue returns a shared slot    (shared build only)
//   empty, almost_empty            occupancy == 0 / == 1
//   full, almost_full, two_free    available == 0 / == 1 / >= 2
//   occupancy         priv_cnt + shr_cnt
module c_mq_queue_counter
  import c_mq_pkg::*;
#(
  parameter int P = 2,
  parameter int C = 3
`ifdef C_MQ_TRACKER_SHARED_EN
  ,
  parameter int PW = 3
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_acc,
  input  logic                        pop_acc,
`ifdef C_MQ_TRACKER_SHARED_EN
  input  logic [PW-1:0]               shared_avail,
  output logic                        shr_take,
  output logic                        shr_release,
`endif
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        two_free,
  output logic [occ_width(P, C)-1:0]  occupancy
);

  localparam int OW  = occ_width(P, C);
  localparam int PCW = cnt_width(P);

  logic [PCW-1:0] priv_cnt;
  int             avail;
  int             occ;

`ifdef C_MQ_TRACKER_SHARED_EN
  localparam int SCW = cnt_width(C);

  logic [SCW-1:0] shr_cnt;
  int             shr_room;
  int             pool_room;

  // Room in the shared pool for this queue is limited both by its own cap
  // and by what the other queues have left in the pool.
  always_comb begin
    shr_room  = C - int'(shr_cnt);
    pool_room = int'(shared_avail);
    avail     = (P - int'(priv_cnt)) + ((shr_room < pool_room) ? shr_room : pool_room);
    occ       = int'(priv_cnt) + int'(shr_cnt);
  end

  // A paired push+pop leaves both counters alone, so strobes fire only for
  // an unpaired operation. Private slots fill first; shared slots drain first.
  assign shr_take    = push_acc & ~pop_acc & (priv_cnt == PCW'(P));
  assign shr_release = pop_acc & ~push_acc & (shr_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      priv_cnt <= '0;
      shr_cnt  <= '0;
    end else if (shr_take) begin
      shr_cnt  <= shr_cnt + SCW'(1);
    end else if (shr_release) begin
      shr_cnt  <= shr_cnt - SCW'(1);
    end else if (push_acc && !pop_acc) begin
      priv_cnt <= priv_cnt + PCW'(1);
    end else if (pop_acc && !push_acc) begin
      priv_cnt <= priv_cnt - PCW'(1);
    end
  end
`else
  always_comb begin
    avail = P - int'(priv_cnt);
    occ   = int'(priv_cnt);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      priv_cnt <= '0;
    end else if (push_acc && !pop_acc) begin
      priv_cnt <= priv_cnt + PCW'(1);
    end else if (pop_acc && !push_acc) begin
      priv_cnt <= priv_cnt - PCW'(1);
    end
  end
`endif

  assign empty        = (occ == 0);
  assign almost_empty = (occ == 1);
  assign full         = (avail == 0);
  assign almost_full  = (avail == 1);
  assign two_free     = (avail >= 2);
  assign occupancy    = OW'(occ);

endmodule

// File: rtl/c_mq_tracker.sv
// c_mq_tracker: buffer state tracker for a hybrid multi-queue. Every queue
// owns num_private_slots private slots and may borrow up to
// max_shared_per_queue slots from a common pool of num_shared_slots.
//
// Optional feature macro: C_MQ_TRACKER_SHARED_EN. When undefined the pool
// is removed and the block is a static num_private_slots-deep tracker;
// shared_free then reads 0.
//
// Handshake: push_valid/pop_valid are single-cycle requests with one-hot
// selects. There is no ready; a request is accepted when the target queue
// is not full (push) / not empty (pop), judged on registered state. A push
// to a full queue is still accepted when paired with a pop from that queue.
// Rejected requests are reported on errors_qu in the same cycle.
//
// Ports:
//   clk, reset, active                 clock, sync active-low reset, enable
//   push_valid, push_sel_qu            push request, one-hot target
//   pop_valid, pop_sel_qu              pop request, one-hot source
//   empty_qu, almost_empty_qu          per-queue occupancy == 0 / == 1
//   full_qu, almost_full_qu, two_free_qu  per-queue available == 0 / 1 / >=2
//   occupancy_qu                       packed per-queue counts, OW bits each
//   shared_free                        free shared slots
//   errors_qu                          per queue {underflow, overflow}
module c_mq_tracker
  import c_mq_pkg::*;
#(
  parameter int num_queues           = 4,
  parameter int num_private_slots    = 2,
  parameter int num_shared_slots     = 4,
  parameter int max_shared_per_queue = 3,
  localparam int OW = occ_width(num_private_slots, max_shared_per_queue),
  localparam int PW = pool_width(num_shared_slots)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       active,
  input  logic                       push_valid,
  input  logic [num_queues-1:0]      push_sel_qu,
  input  logic                       pop_valid,
  input  logic [num_queues-1:0]      pop_sel_qu,
  output logic [num_queues-1:0]      empty_qu,
  output logic [num_queues-1:0]      almost_empty_qu,
  output logic [num_queues-1:0]      full_qu,
  output logic [num_queues-1:0]      almost_full_qu,
  output logic [num_queues-1:0]      two_free_qu,
  output logic [num_queues*OW-1:0]   occupancy_qu,
  output logic [PW-1:0]              shared_free,
  output logic [num_queues*2-1:0]    errors_qu
);

  logic [num_queues-1:0] push_hit;
  logic [num_queues-1:0] pop_hit;
  logic [num_queues-1:0] push_acc;
  logic [num_queues-1:0] pop_acc;

  assign push_hit = {num_queues{push_valid}} & push_sel_qu;
  assign pop_hit  = {num_queues{pop_valid}} & pop_sel_qu;

  // A full queue is never empty, so a paired pop always makes room for the push.
  assign pop_acc  = {num_queues{active}} & pop_hit & ~empty_qu;
  assign push_acc = {num_queues{active}} & push_hit & (~full_qu | pop_acc);

  always_comb begin
    errors_qu = '0;
    for (int q = 0; q < num_queues; q++) begin
      errors_qu[2*q + ERR_OVERFLOW]  = active & push_hit[q] & full_qu[q] & ~pop_hit[q];
      errors_qu[2*q + ERR_UNDERFLOW] = active & pop_hit[q] & empty_qu[q];
    end
  end

`ifdef C_MQ_TRACKER_SHARED_EN
  logic [num_queues-1:0] shr_take;
  logic [num_queues-1:0] shr_release;
  logic [PW-1:0]         shared_used;
  logic                  take_any;
  logic                  release_any;

  // One push and one pop per cycle, so at most one take and one release.
  assign take_any    = |shr_take;
  assign release_any = |shr_release;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shared_used <= '0;
    end else if (take_any && !release_any) begin
      shared_used <= shared_used + PW'(1);
    end else if (release_any && !take_any) begin
      shared_used <= shared_used - PW'(1);
    end
  end

  assign shared_free = PW'(num_shared_slots) - shared_used;
`else
  assign shared_free = '0;
`endif

  for (genvar q = 0; q < num_queues; q++) begin : g_queue
    c_mq_queue_counter #(
      .P  (num_private_slots),
      .C  (max_shared_per_queue)
`ifdef C_MQ_TRACKER_SHARED_EN
      ,
      .PW (PW)
`endif
    ) u_counter (
      .clk          (clk),
      .reset        (reset),
      .push_acc     (push_acc[q]),
      .pop_acc      (pop_acc[q]),
`ifdef C_MQ_TRACKER_SHARED_EN
      .shared_avail (shared_free),
      .shr_take     (shr_take[q]),
      .shr_release  (shr_release[q]),
`endif
      .empty        (empty_qu[q]),
      .almost_empty (almost_empty_qu[q]),
      .full         (full_qu[q]),
      .almost_full  (almost_full_qu[q]),
      .two_free     (two_free_qu[q]),
      .occupancy    (occupancy_qu[q*OW +: OW])
    );
  end

endmodule
